// File: rtl/core_pipe_pkg.sv
// ---------------------------------------------------------------------------
// core_pipe_pkg
// Shared definitions for the RV32I pipeline sequencing controller:
// controller state encoding, the x0 register number and counter widths.
// ---------------------------------------------------------------------------
package core_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_IO_WAIT = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         FLUSH_CNT_W = 4;
    localparam int         IO_CNT_W    = 16;

endpackage

// File: rtl/core_pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// core_pipe_ctrl_if
// Bundles the decode/EX/writeback/IO-port signals seen by core_pipe_ctrl.
//   master : pipeline side, drives ID_*, BR_TAKEN, WB_*, IO_ACK
//   slave  : the controller, drives ISSUE, STALL, FLUSH, IO_REQ,
//            IO_TIMEOUT and BUSY_MAP
// ---------------------------------------------------------------------------
interface core_pipe_ctrl_if;

    logic        ID_VALID;
    logic [4:0]  ID_RS1;
    logic [4:0]  ID_RS2;
    logic [4:0]  ID_RD;
    logic        ID_LONG;
    logic        ID_IO;
    logic        BR_TAKEN;
    logic        WB_VALID;
    logic [4:0]  WB_RD;
    logic        IO_ACK;
    logic        ISSUE;
    logic        STALL;
    logic        FLUSH;
    logic        IO_REQ;
    logic        IO_TIMEOUT;
    logic [31:0] BUSY_MAP;

    modport master (
        output ID_VALID, ID_RS1, ID_RS2, ID_RD, ID_LONG, ID_IO,
        output BR_TAKEN, WB_VALID, WB_RD, IO_ACK,
        input  ISSUE, STALL, FLUSH, IO_REQ, IO_TIMEOUT, BUSY_MAP
    );

    modport slave (
        input  ID_VALID, ID_RS1, ID_RS2, ID_RD, ID_LONG, ID_IO,
        input  BR_TAKEN, WB_VALID, WB_RD, IO_ACK,
        output ISSUE, STALL, FLUSH, IO_REQ, IO_TIMEOUT, BUSY_MAP
    );

endinterface

// File: rtl/core_scoreboard.sv
// ---------------------------------------------------------------------------
// core_scoreboard
// Pending-result bitmap for long-latency destinations (loads, IN).
//   CLK, RST_N      : clock, synchronous active-low reset
//   set_en/set_rd   : mark set_rd pending (wins over a same-cycle clear)
//   clr_en/clr_rd   : writeback clears clr_rd; also bypasses the hazard
//   kill_en/kill_rd : IO-timeout abort clears kill_rd (no bypass)
//   rd_valid        : the reading instruction is valid
//   rs1/rs2         : source registers to check
//   haz             : read-after-write hazard on rs1/rs2
//   map             : current bitmap (bit 0 always 0)
// ---------------------------------------------------------------------------
module core_scoreboard
    import core_pipe_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        set_en,
    input  logic [4:0]  set_rd,
    input  logic        clr_en,
    input  logic [4:0]  clr_rd,
    input  logic        kill_en,
    input  logic [4:0]  kill_rd,
    input  logic        rd_valid,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        haz,
    output logic [31:0] map
);

    logic [31:0] map_q;
    logic [31:0] map_d;
    logic [31:0] pend;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] kill_mask;

    assign set_mask  = (set_en  && set_rd  != REG_ZERO) ? (32'd1 << set_rd)  : 32'd0;
    assign clr_mask  = clr_en  ? (32'd1 << clr_rd)  : 32'd0;
    assign kill_mask = kill_en ? (32'd1 << kill_rd) : 32'd0;

    // A writeback in the same cycle is forwarded in EX, so it no longer blocks.
    assign pend = map_q & ~clr_mask;
    assign haz  = rd_valid & (((rs1 != REG_ZERO) & pend[rs1]) |
                              ((rs2 != REG_ZERO) & pend[rs2]));

    // Kept separate from the hazard logic: set_en depends on haz upstream.
    always_comb begin
        map_d    = (map_q & ~clr_mask & ~kill_mask) | set_mask;
        map_d[0] = 1'b0;
    end

    // NOTE: the bitmap is plain flops, not a RAM, so it is reset like any
    // other state register; sequential state is always written with <=.
    always_ff @(posedge CLK) begin
        if (!RST_N) map_q <= '0;
        else        map_q <= map_d;
    end

    assign map = map_q;

endmodule

// File: rtl/core_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// core_pipe_ctrl
// Pipeline sequencing controller between decode and execute: decides each
// cycle whether the decoded instruction issues, stalls on RAW hazards
// against pending long-latency results, flushes IF/ID after taken branches
// and runs the IN/OUT request/acknowledge handshake with timeout.
//   CLK, RST_N : clock, synchronous active-low reset
//   bus        : core_pipe_ctrl_if.slave (decode, EX, WB and IO signals)
// Parameters:
//   FLUSH_CYCLES   : cycles FLUSH is asserted after a taken branch (1..15)
//   IO_TIMEOUT_CYC : cycles IO_REQ waits for IO_ACK (1..65535)
// ---------------------------------------------------------------------------
module core_pipe_ctrl
    import core_pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES   = 2,
    parameter int IO_TIMEOUT_CYC = 255
) (
    input  logic             CLK,
    input  logic             RST_N,
    core_pipe_ctrl_if.slave  bus
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [IO_CNT_W-1:0]    IO_LAST    = IO_CNT_W'(IO_TIMEOUT_CYC - 1);

    state_t                 state_q, state_d;
    logic [FLUSH_CNT_W-1:0] fcnt_q, fcnt_d;
    logic [IO_CNT_W-1:0]    iocnt_q, iocnt_d;
    logic                   io_req_q, io_req_d;
    logic                   io_to_q, io_to_d;
    logic [4:0]             io_rd_q, io_rd_d;

    logic        haz;
    logic        issue;
    logic        stall;
    logic        flush;
    logic        kill_en;
    logic [31:0] map;

    core_scoreboard u_scoreboard (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .set_en   (issue & bus.ID_LONG),
        .set_rd   (bus.ID_RD),
        .clr_en   (bus.WB_VALID),
        .clr_rd   (bus.WB_RD),
        .kill_en  (kill_en),
        .kill_rd  (io_rd_q),
        .rd_valid (bus.ID_VALID),
        .rs1      (bus.ID_RS1),
        .rs2      (bus.ID_RS2),
        .haz      (haz),
        .map      (map)
    );

    // NOTE: every signal written here gets a default first so no path
    // through the case leaves one unassigned (which would infer a latch).
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        iocnt_d  = iocnt_q;
        io_req_d = io_req_q;
        io_to_d  = 1'b0;
        io_rd_d  = io_rd_q;
        issue    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        kill_en  = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (bus.BR_TAKEN) begin
                    flush   = 1'b1;
                    fcnt_d  = FLUSH_LOAD;
                    state_d = (FLUSH_LOAD != '0) ? ST_FLUSH : ST_RUN;
                end else begin
                    issue = bus.ID_VALID & ~haz;
                    stall = haz;
                    if (issue && bus.ID_IO) begin
                        state_d  = ST_IO_WAIT;
                        io_req_d = 1'b1;
                        iocnt_d  = '0;
                        // Only IN has a destination the abort path must release.
                        io_rd_d  = bus.ID_LONG ? bus.ID_RD : REG_ZERO;
                    end
                end
            end

            ST_FLUSH: begin
                // The branch cycle itself was the first flush cycle, so leave
                // once the counter decrements to zero.
                flush = 1'b1;
                if (fcnt_q <= FLUSH_CNT_W'(1)) begin
                    fcnt_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - FLUSH_CNT_W'(1);
                end
            end

            ST_IO_WAIT: begin
                stall = 1'b1;
                if (bus.IO_ACK) begin
                    io_req_d = 1'b0;
                    state_d  = ST_RUN;
                end else if (iocnt_q == IO_LAST) begin
                    io_to_d  = 1'b1;
                    io_req_d = 1'b0;
                    kill_en  = 1'b1;
                    state_d  = ST_RUN;
                end else if (iocnt_q != '1) begin
                    iocnt_d = iocnt_q + IO_CNT_W'(1);
                end
            end

            default: state_d = ST_RUN;
        endcase

        if (!RST_N) begin
            issue   = 1'b0;
            stall   = 1'b0;
            flush   = 1'b0;
            kill_en = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= ST_RUN;
            fcnt_q   <= '0;
            iocnt_q  <= '0;
            io_req_q <= 1'b0;
            io_to_q  <= 1'b0;
            io_rd_q  <= REG_ZERO;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            iocnt_q  <= iocnt_d;
            io_req_q <= io_req_d;
            io_to_q  <= io_to_d;
            io_rd_q  <= io_rd_d;
        end
    end

    assign bus.ISSUE      = issue;
    assign bus.STALL      = stall;
    assign bus.FLUSH      = flush;
    assign bus.IO_REQ     = io_req_q;
    assign bus.IO_TIMEOUT = io_to_q;
    assign bus.BUSY_MAP   = map;

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_pipe_ctrl
// Directed bench for core_pipe_ctrl (FLUSH_CYCLES=2, IO_TIMEOUT_CYC=8).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_core_pipe_ctrl;

    logic CLK;
    logic RST_N;
    int   checks   = 0;
    int   failures = 0;

    core_pipe_ctrl_if bus ();

    core_pipe_ctrl #(
        .FLUSH_CYCLES   (2),
        .IO_TIMEOUT_CYC (8)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.ID_VALID = 1'b0;
        bus.ID_RS1   = 5'd0;
        bus.ID_RS2   = 5'd0;
        bus.ID_RD    = 5'd0;
        bus.ID_LONG  = 1'b0;
        bus.ID_IO    = 1'b0;
        bus.BR_TAKEN = 1'b0;
        bus.WB_VALID = 1'b0;
        bus.WB_RD    = 5'd0;
        bus.IO_ACK   = 1'b0;
    endtask

    task automatic setid(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic lng, input logic io);
        bus.ID_VALID = v;
        bus.ID_RS1   = rs1;
        bus.ID_RS2   = rs2;
        bus.ID_RD    = rd;
        bus.ID_LONG  = lng;
        bus.ID_IO    = io;
    endtask

    initial begin
        // Reset with active-looking inputs: combinational outputs stay low.
        idle();
        RST_N = 1'b0;
        setid(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
        bus.BR_TAKEN = 1'b1;
        #1;
        check("rst_issue", bus.ISSUE, 0);
        check("rst_stall", bus.STALL, 0);
        check("rst_flush", bus.FLUSH, 0);
        tick();
        tick();
        idle();
        #1;
        check("rst_io_req", bus.IO_REQ, 0);
        check("rst_io_timeout", bus.IO_TIMEOUT, 0);
        check("rst_map", bus.BUSY_MAP, 0);
        RST_N = 1'b1;

        // Load x5, then a reader of x5 stalls until the writeback.
        setid(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        #1;
        check("load_issue", bus.ISSUE, 1);
        check("load_nostall", bus.STALL, 0);
        tick();
        setid(1'b1, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0);
        #1;
        check("map_x5", bus.BUSY_MAP, 32'h0000_0020);
        check("raw_stall", bus.STALL, 1);
        check("raw_noissue", bus.ISSUE, 0);
        tick();
        check("raw_stall_hold", bus.STALL, 1);
        bus.WB_VALID = 1'b1;
        bus.WB_RD    = 5'd5;
        #1;
        check("wb_bypass_issue", bus.ISSUE, 1);
        check("wb_bypass_nostall", bus.STALL, 0);
        tick();
        idle();
        #1;
        check("map_x5_clr", bus.BUSY_MAP, 0);

        // Taken branch: FLUSH for exactly two cycles, BR_TAKEN ignored in FLUSH.
        setid(1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
        bus.BR_TAKEN = 1'b1;
        #1;
        check("br_noissue", bus.ISSUE, 0);
        check("br_flush1", bus.FLUSH, 1);
        tick();
        check("br_flush2", bus.FLUSH, 1);
        check("br_flush2_noissue", bus.ISSUE, 0);
        check("br_flush2_nostall", bus.STALL, 0);
        tick();
        bus.BR_TAKEN = 1'b0;
        #1;
        check("br_run_noflush", bus.FLUSH, 0);
        check("br_run_issue", bus.ISSUE, 1);
        idle();

        // OUT with IO_ACK in the fourth wait cycle.
        setid(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1);
        #1;
        check("out_issue", bus.ISSUE, 1);
        tick();
        setid(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) bus.IO_ACK = 1'b1;
            #1;
            check($sformatf("out_req_c%0d", k), bus.IO_REQ, 1);
            check($sformatf("out_stall_c%0d", k), bus.STALL, 1);
            check($sformatf("out_noissue_c%0d", k), bus.ISSUE, 0);
            check($sformatf("out_noto_c%0d", k), bus.IO_TIMEOUT, 0);
            tick();
        end
        bus.IO_ACK = 1'b0;
        #1;
        check("out_req_drop", bus.IO_REQ, 0);
        check("out_noto_end", bus.IO_TIMEOUT, 0);
        check("out_run_nostall", bus.STALL, 0);
        check("out_run_issue", bus.ISSUE, 1);
        idle();

        // IN to x7 with no ack: timeout after 8 request cycles frees x7.
        setid(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
        #1;
        check("in7_issue", bus.ISSUE, 1);
        tick();
        idle();
        check("in7_map", bus.BUSY_MAP, 32'h0000_0080);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("in7_req_c%0d", k), bus.IO_REQ, 1);
            check($sformatf("in7_noto_c%0d", k), bus.IO_TIMEOUT, 0);
            tick();
        end
        check("in7_timeout", bus.IO_TIMEOUT, 1);
        check("in7_req_drop", bus.IO_REQ, 0);
        check("in7_map_clr", bus.BUSY_MAP, 0);
        check("in7_run_nostall", bus.STALL, 0);
        tick();
        check("in7_pulse_end", bus.IO_TIMEOUT, 0);

        // IN to x9, ack on the cycle the timeout would fire: ack wins.
        setid(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
        tick();
        idle();
        for (int k = 0; k < 7; k++) tick();
        bus.IO_ACK = 1'b1;
        tick();
        bus.IO_ACK = 1'b0;
        check("ack_wins_noto", bus.IO_TIMEOUT, 0);
        check("ack_wins_req", bus.IO_REQ, 0);
        check("ack_wins_map", bus.BUSY_MAP, 32'h0000_0200);
        bus.WB_VALID = 1'b1;
        bus.WB_RD    = 5'd9;
        tick();
        idle();

        // Same-cycle writeback and long issue to x3: set wins.
        setid(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        tick();
        check("x3_pending", bus.BUSY_MAP, 32'h0000_0008);
        bus.WB_VALID = 1'b1;
        bus.WB_RD    = 5'd3;
        #1;
        check("x3_reissue", bus.ISSUE, 1);
        tick();
        idle();
        check("x3_set_wins", bus.BUSY_MAP, 32'h0000_0008);
        setid(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        #1;
        check("x0_nostall", bus.STALL, 0);
        check("x0_issue", bus.ISSUE, 1);
        tick();
        check("x0_never_set", bus.BUSY_MAP, 32'h0000_0008);
        setid(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check("x3_rs1_stall", bus.STALL, 1);
        setid(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
        #1;
        check("x3_rs2_stall", bus.STALL, 1);
        idle();

        // Reset while in IO_WAIT.
        setid(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        #1;
        check("rio_issue", bus.ISSUE, 1);
        tick();
        idle();
        check("rio_req", bus.IO_REQ, 1);
        RST_N = 1'b0;
        tick();
        check("rio_req_drop", bus.IO_REQ, 0);
        check("rio_noto", bus.IO_TIMEOUT, 0);
        check("rio_map_clr", bus.BUSY_MAP, 0);
        RST_N = 1'b1;
        setid(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check("rio_run_nostall", bus.STALL, 0);
        check("rio_run_issue", bus.ISSUE, 1);
        tick();
        idle();
        check("rio_noto_after", bus.IO_TIMEOUT, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
